// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, default widths and zero-register helper for regfile_mp.
package regfile_pkg;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  function automatic logic zero_prot(input int idx, input int zr);
    return zr != 0 && idx == 0;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits; reserve beats a same-cycle clearing write.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int DEPTH = 2**ADDR_W
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     run,
  input  logic                     set,
  input  logic [ADDR_W-1:0]        set_n,
  input  logic                     c0,
  input  logic [ADDR_W-1:0]        c0_n,
  input  logic                     c1,
  input  logic [ADDR_W-1:0]        c1_n,
  input  logic [NUM_RD*ADDR_W-1:0] rn,
  output logic [NUM_RD-1:0]        busy
);
  logic [DEPTH-1:0] pend, pend_n;
  always_comb begin
    pend_n = pend;
    if (c0) pend_n[c0_n] = 1'b0;
    if (c1) pend_n[c1_n] = 1'b0;
    if (set) pend_n[set_n] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (clr) pend <= '0;
    else pend <= pend_n;
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
    assign busy[k] = run && pend[rn[k*ADDR_W +: ADDR_W]];
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port MIPS register file with pending scoreboard and post-reset clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NUM_RD*ADDR_W-1:0] rn,
  output logic [NUM_RD*DATA_W-1:0] q,
  output logic [NUM_RD-1:0]        busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wn0,
  input  logic [DATA_W-1:0]        d0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wn1,
  input  logic [DATA_W-1:0]        d1,
  input  logic                     rsv,
  input  logic [ADDR_W-1:0]        rsv_n,
  output logic                     ready
);
  localparam int DEPTH = 2**ADDR_W;
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic run, w0, w1, rs;
  logic [NUM_RD-1:0] sb_busy;
  assign run = state == ST_RUN;
  assign ready = run;
  assign w1 = run && we1 && !zero_prot(int'(wn1), ZERO_REG);
  assign w0 = run && we0 && !zero_prot(int'(wn0), ZERO_REG) && !(w1 && wn1 == wn0);
  assign rs = run && rsv && !zero_prot(int'(rsv_n), ZERO_REG);
  always_ff @(posedge clk) begin
    state <= state_n;
    cnt <= cnt_n;
  end
  always_comb begin
    state_n = state;
    cnt_n = run ? cnt : cnt + 1'b1;
    if (clr) begin
      state_n = ST_INIT;
      cnt_n = '0;
    end else if (!run && cnt == '1) state_n = ST_RUN;
  end
  // No reset on the array: the sweep clears it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (!run) mem[cnt] <= '0;
      if (w0) mem[wn0] <= d0;
      if (w1) mem[wn1] <= d1;
    end
  end
  regfile_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .DEPTH(DEPTH)) u_sb (
    .clk(clk), .clr(clr), .run(run), .set(rs), .set_n(rsv_n),
    .c0(w0), .c0_n(wn0), .c1(w1), .c1_n(wn1), .rn(rn), .busy(sb_busy)
  );
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] r;
    logic zr;
    assign r = rn[k*ADDR_W +: ADDR_W];
    assign zr = !run || zero_prot(int'(r), ZERO_REG);
`ifdef REGFILE_BYPASS_EN
    logic hit0, hit1;
    assign hit1 = w1 && wn1 == r;
    assign hit0 = w0 && wn0 == r;
    assign q[k*DATA_W +: DATA_W] = zr ? '0 : hit1 ? d1 : hit0 ? d0 : mem[r];
    assign busy[k] = sb_busy[k] && !hit1 && !hit0;
`else
    assign q[k*DATA_W +: DATA_W] = zr ? '0 : mem[r];
    assign busy[k] = sb_busy[k];
`endif
  end
endmodule
